// File: rtl/lcd_power_sequencer_pkg.sv
// Shared definitions for the LVDS panel power sequencer: state encodings,
// default panel delays and small decode helpers.
package lcd_power_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_LINK_UP   = 3'd2,
        ST_RUN       = 3'd3,
        ST_BL_OFF    = 3'd4,
        ST_LINK_DOWN = 3'd5
    } seq_state_t;

    localparam int unsigned DWELL_W       = 32;
    localparam int unsigned T_VID2BL_DEF  = 20_000_000;
    localparam int unsigned T_BL2VID_DEF  = 20_000_000;
    localparam int unsigned T_OFF_MIN_DEF = 50_000_000;
    localparam int unsigned PWM_DIV_DEF   = 16;

    // The LVDS link (and with it the timing generator) is live in these states.
    function automatic logic link_active(seq_state_t s);
        return (s == ST_LINK_UP) || (s == ST_RUN) || (s == ST_BL_OFF);
    endfunction

endpackage

// File: rtl/lcd_pwm_gen.sv
// Backlight PWM: prescaled 8-bit counter with a duty value that is only
// updated at period boundaries, so brightness changes never glitch a period.
module lcd_pwm_gen
    import lcd_power_sequencer_pkg::*;
#(
    parameter int unsigned PWM_DIV = PWM_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] brightness,
    output logic       led_pwm
);

    localparam int unsigned PRESC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PWM_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         duty_q, duty_d;
    logic               en_q;
    logic               pwm_q, pwm_d;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        if (!enable) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (!en_q) begin
            duty_d = brightness;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'hFF) begin
                duty_d = brightness;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
        // Decoded from next-state values so the flop matches the counter it describes.
        pwm_d = enable && ((duty_d == 8'hFF) || (cnt_d < duty_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            en_q    <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            en_q    <= enable;
            pwm_q   <= pwm_d;
        end
    end

    assign led_pwm = pwm_q;

endmodule

// File: rtl/lcd_power_sequencer.sv
// LVDS panel power sequencer: gates video on MMCM lock, times link/backlight
// delays with a single dwell counter and drives the backlight PWM.
module lcd_power_sequencer
    import lcd_power_sequencer_pkg::*;
#(
    parameter int unsigned T_VID2BL  = T_VID2BL_DEF,
    parameter int unsigned T_BL2VID  = T_BL2VID_DEF,
    parameter int unsigned T_OFF_MIN = T_OFF_MIN_DEF,
    parameter int unsigned PWM_DIV   = PWM_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       pll_locked,
    input  logic [7:0] brightness,
    output logic       video_en,
    output logic       led_en,
    output logic       led_pwm,
    output logic       panel_ready,
    output logic [2:0] seq_state
);

    localparam logic [DWELL_W-1:0] VID2BL_LD = DWELL_W'(T_VID2BL - 1);
    localparam logic [DWELL_W-1:0] BL2VID_LD = DWELL_W'(T_BL2VID - 1);
    localparam logic [DWELL_W-1:0] OFF_LD    = DWELL_W'(T_OFF_MIN - 1);

    seq_state_t         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               video_en_q, led_en_q, ready_q;
    logic               run_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (pwr_req) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!pwr_req) begin
                    state_d = ST_OFF;
                end else if (pll_locked) begin
                    state_d = ST_LINK_UP;
                    cnt_d   = VID2BL_LD;
                end
            end
            ST_LINK_UP: begin
                // An abort outranks the timer: the backlight must never come on without lock.
                if (!pwr_req || !pll_locked) begin
                    state_d = ST_LINK_DOWN;
                    cnt_d   = OFF_LD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (!pwr_req || !pll_locked) begin
                    state_d = ST_BL_OFF;
                    cnt_d   = BL2VID_LD;
                end
            end
            ST_BL_OFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_LINK_DOWN;
                    cnt_d   = OFF_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LINK_DOWN: begin
                if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign run_d = (state_d == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            video_en_q <= 1'b0;
            led_en_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            video_en_q <= link_active(state_d);
            led_en_q   <= run_d;
            ready_q    <= run_d;
        end
    end

    lcd_pwm_gen #(
        .PWM_DIV(PWM_DIV)
    ) u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (run_d),
        .brightness(brightness),
        .led_pwm   (led_pwm)
    );

    assign video_en    = video_en_q;
    assign led_en      = led_en_q;
    assign panel_ready = ready_q;
    assign seq_state   = state_q;

endmodule
